pipelined_rca_adder: RTL



---
 rtl/pipelined_rca_adder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipelined_rca_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipelined_rca_adder                                                      |
// | Valid/ready pipelined ripple-carry add/subtract, CHUNK bits per stage.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipelined_rca_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;

   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] carry_q;
   logic [WIDTH-1:0]  opa_q  [STAGES];
   logic [WIDTH-1:0]  opb_q  [STAGES];
   logic [WIDTH-1:0]  sum_q  [STAGES];
   logic              ovf_q;

   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] carry_d;
   logic [WIDTH-1:0]  opa_d  [STAGES];
   logic [WIDTH-1:0]  opb_d  [STAGES];
   logic [WIDTH-1:0]  sum_d  [STAGES];
   logic              ovf_d;
   logic [STAGES-1:0] stage_rdy;

   // A stage can load when it is empty or everything downstream of it moves.
   always_comb begin
      logic run;
      run = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         run          = !valid_q[k] || run;
         stage_rdy[k] = run;
      end
   end

   // Subtraction is folded in at entry: B is inverted and the borrow flipped,
   // so every stage is a plain adder and the inverted B travels with the beat.
   always_comb begin
      logic [WIDTH-1:0] src_a, src_b, src_s, nxt_s;
      logic             src_c, src_v, c, c_msb;
      int               idx;
      src_a = a;
      src_b = sub ? ~b : b;
      src_c = sub ? ~cin : cin;
      src_s = '0;
      src_v = in_valid;
      ovf_d = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         c     = src_c;
         nxt_s = src_s;
         c_msb = 1'b0;
         for (int i = 0; i < CHUNK; i++) begin
            idx        = k * CHUNK + i;
            nxt_s[idx] = src_a[idx] ^ src_b[idx] ^ c;
            if (idx == WIDTH - 1) begin
               c_msb = c;
            end
            c = (src_a[idx] & src_b[idx]) | (c & (src_a[idx] ^ src_b[idx]));
         end
         opa_d[k]   = src_a;
         opb_d[k]   = src_b;
         sum_d[k]   = nxt_s;
         carry_d[k] = c;
         valid_d[k] = src_v;
         ovf_d      = c_msb ^ c;
         src_a      = opa_q[k];
         src_b      = opb_q[k];
         src_c      = carry_q[k];
         src_s      = sum_q[k];
         src_v      = valid_q[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         carry_q <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            opa_q[k] <= '0;
            opb_q[k] <= '0;
            sum_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (stage_rdy[k]) begin
               valid_q[k] <= valid_d[k];
               // Data only moves with a real beat so idle X never enters the pipe.
               if (valid_d[k]) begin
                  opa_q[k]   <= opa_d[k];
                  opb_q[k]   <= opb_d[k];
                  sum_q[k]   <= sum_d[k];
                  carry_q[k] <= carry_d[k];
               end
            end
         end
         if (stage_rdy[STAGES-1] && valid_d[STAGES-1]) begin
            ovf_q <= ovf_d;
         end
      end
   end

   assign in_ready  = stage_rdy[0];
   assign out_valid = valid_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign co        = carry_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule
`default_nettype wire
